// File: rtl/my_heart_chorus_if.sv
// Heart chorus bus: per-channel love/tranquillity levels in, per-channel
// heart state, heartbeat pulses and the chorus-wide peace flag out.
interface my_heart_chorus_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0]   love;
    logic [CHANNELS-1:0]   tranquillity;
    logic [2*CHANNELS-1:0] heart;
    logic [CHANNELS-1:0]   life;
    logic                  all_peace;

    modport master (
        output love,
        output tranquillity,
        input  heart,
        input  life,
        input  all_peace
    );

    modport slave (
        input  love,
        input  tranquillity,
        output heart,
        output life,
        output all_peace
    );
endinterface

// File: rtl/my_heart_chorus.sv
// my_heart_chorus: a bank of independent heart state machines.
// Each channel moves EMPTY -> LOVING -> PEACEFUL / BROKEN depending on how
// long love and tranquillity persist, and emits a heartbeat pulse whose
// period doubles once the heart is PEACEFUL.
// Optional feature macro: HEART_MENDING_EN -- when defined, a BROKEN heart
// that sees love and tranquillity together returns to EMPTY; otherwise
// BROKEN is left only through reset.
module my_heart_chorus #(
    parameter int CHANNELS       = 4,
    parameter int CALM_CYCLES    = 4,
    parameter int LONGING_CYCLES = 8,
    parameter int BEAT_PERIOD    = 4
) (
    input  logic              clk,
    input  logic              reset,
    my_heart_chorus_if.slave  bus
);

    typedef enum logic [1:0] {
        EMPTY    = 2'b00,
        LOVING   = 2'b01,
        PEACEFUL = 2'b10,
        BROKEN   = 2'b11
    } heart_state_t;

    localparam int MAX_COUNT = (CALM_CYCLES > LONGING_CYCLES) ? CALM_CYCLES : LONGING_CYCLES;
    localparam int CW        = $clog2(MAX_COUNT + 1);
    localparam int BW        = $clog2(2 * BEAT_PERIOD);

    localparam logic [CW-1:0] CALM_LAST     = CW'(CALM_CYCLES - 1);
    localparam logic [CW-1:0] LONGING_LAST  = CW'(LONGING_CYCLES - 1);
    localparam logic [CW-1:0] COUNT_FULL    = {CW{1'b1}};
    localparam logic [BW-1:0] LOVING_LAST   = BW'(BEAT_PERIOD - 1);
    localparam logic [BW-1:0] PEACEFUL_LAST = BW'(2 * BEAT_PERIOD - 1);

    heart_state_t        state_q   [CHANNELS];
    logic [CW-1:0]       calm_q    [CHANNELS];
    logic [CW-1:0]       longing_q [CHANNELS];
    logic [BW-1:0]       beat_q    [CHANNELS];
    logic [CHANNELS-1:0] life_q;
    logic                all_peace_q;
    logic                every_peaceful;

    // Flags when every channel's registered state is PEACEFUL.
    always_comb begin
        every_peaceful = 1'b1;
        for (int i = 0; i < CHANNELS; i++) begin
            if (state_q[i] != PEACEFUL) begin
                every_peaceful = 1'b0;
            end
        end
    end

    // Per-channel heart FSM with its calm, longing and beat counters; any
    // state change clears all three counters and suppresses the pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i]   <= EMPTY;
                calm_q[i]    <= '0;
                longing_q[i] <= '0;
                beat_q[i]    <= '0;
            end
            life_q      <= '0;
            all_peace_q <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                case (state_q[i])
                    EMPTY: begin
                        calm_q[i]    <= '0;
                        longing_q[i] <= '0;
                        beat_q[i]    <= '0;
                        life_q[i]    <= 1'b0;
                        if (bus.love[i]) begin
                            state_q[i] <= LOVING;
                        end
                    end
                    LOVING: begin
                        if (bus.love[i] && bus.tranquillity[i] && calm_q[i] == CALM_LAST) begin
                            state_q[i]   <= PEACEFUL;
                            calm_q[i]    <= '0;
                            longing_q[i] <= '0;
                            beat_q[i]    <= '0;
                            life_q[i]    <= 1'b0;
                        end else if (!bus.love[i] && longing_q[i] == LONGING_LAST) begin
                            state_q[i]   <= BROKEN;
                            calm_q[i]    <= '0;
                            longing_q[i] <= '0;
                            beat_q[i]    <= '0;
                            life_q[i]    <= 1'b0;
                        end else begin
                            if (bus.love[i] && bus.tranquillity[i]) begin
                                calm_q[i] <= (calm_q[i] == COUNT_FULL) ? calm_q[i] : calm_q[i] + 1'b1;
                            end else begin
                                calm_q[i] <= '0;
                            end
                            if (!bus.love[i]) begin
                                longing_q[i] <= (longing_q[i] == COUNT_FULL) ? longing_q[i] : longing_q[i] + 1'b1;
                            end else begin
                                longing_q[i] <= '0;
                            end
                            if (beat_q[i] == LOVING_LAST) begin
                                beat_q[i] <= '0;
                                life_q[i] <= 1'b1;
                            end else begin
                                beat_q[i] <= beat_q[i] + 1'b1;
                                life_q[i] <= 1'b0;
                            end
                        end
                    end
                    PEACEFUL: begin
                        calm_q[i]    <= '0;
                        longing_q[i] <= '0;
                        if (!(bus.love[i] && bus.tranquillity[i])) begin
                            state_q[i] <= LOVING;
                            beat_q[i]  <= '0;
                            life_q[i]  <= 1'b0;
                        end else if (beat_q[i] == PEACEFUL_LAST) begin
                            beat_q[i] <= '0;
                            life_q[i] <= 1'b1;
                        end else begin
                            beat_q[i] <= beat_q[i] + 1'b1;
                            life_q[i] <= 1'b0;
                        end
                    end
                    default: begin
                        calm_q[i]    <= '0;
                        longing_q[i] <= '0;
                        beat_q[i]    <= '0;
                        life_q[i]    <= 1'b0;
`ifdef HEART_MENDING_EN
                        if (bus.love[i] && bus.tranquillity[i]) begin
                            state_q[i] <= EMPTY;
                        end
`else
                        state_q[i] <= BROKEN;
`endif
                    end
                endcase
            end
            all_peace_q <= every_peaceful;
        end
    end

    // Packs the registered channel states onto the heart bus.
    always_comb begin
        bus.heart = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            bus.heart[2*i +: 2] = state_q[i];
        end
    end

    assign bus.life      = life_q;
    assign bus.all_peace = all_peace_q;

endmodule

// File: tb/tb_my_heart_chorus.sv
// Self-checking bench for my_heart_chorus (default parameters).
// Vectors hold inputs plus the outputs expected after the following edge;
// expectations are queued when a vector is driven and popped at the check.
module tb_my_heart_chorus;

    localparam int CH = 4;

    typedef struct packed {
        logic       rst;
        logic [3:0] love;
        logic [3:0] tranq;
        logic [7:0] heart;
        logic [3:0] life;
        logic       all_peace;
    } vec_t;

    typedef struct {
        int         tag;
        logic [7:0] heart;
        logic [3:0] life;
        logic       all_peace;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    my_heart_chorus_if #(.CHANNELS(CH)) bus();

    my_heart_chorus #(
        .CHANNELS(CH),
        .CALM_CYCLES(4),
        .LONGING_CYCLES(8),
        .BEAT_PERIOD(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   rowNum = 0;
    exp_t expQ[$];
    vec_t tableQ[$];

    function automatic vec_t mk(input logic r, input logic [3:0] l, input logic [3:0] t,
                                input logic [7:0] h, input logic [3:0] lf, input logic ap);
        vec_t v;
        v.rst = r; v.love = l; v.tranq = t;
        v.heart = h; v.life = lf; v.all_peace = ap;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        exp_t e;
        @(negedge clk);
        reset            = v.rst;
        bus.love         = v.love;
        bus.tranquillity = v.tranq;
        e.tag       = rowNum;
        e.heart     = v.heart;
        e.life      = v.life;
        e.all_peace = v.all_peace;
        expQ.push_back(e);
        rowNum++;
    endtask

    task automatic checkOutput();
        exp_t e;
        @(posedge clk);
        #1;
        checks++;
        if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard: no expected entry, got heart=%h", bus.heart);
            return;
        end
        e = expQ.pop_front();
        if (bus.heart !== e.heart) begin
            errors++;
            $display("[TB] FAIL heart row %0d: got %h expected %h", e.tag, bus.heart, e.heart);
        end
        checks++;
        if (bus.life !== e.life) begin
            errors++;
            $display("[TB] FAIL life row %0d: got %b expected %b", e.tag, bus.life, e.life);
        end
        checks++;
        if (bus.all_peace !== e.all_peace) begin
            errors++;
            $display("[TB] FAIL all_peace row %0d: got %b expected %b", e.tag, bus.all_peace, e.all_peace);
        end
    endtask

    task automatic step(input vec_t v);
        applyStimulus(v);
        checkOutput();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset            = 1'b1;
        bus.love         = '0;
        bus.tranquillity = '0;

        // Reset, channel 0 enters LOVING, beats at 4, calm run broken then completed.
        tableQ.push_back(mk(1'b1, 4'b0000, 4'b0000, 8'h00, 4'b0000, 1'b0));
        tableQ.push_back(mk(1'b1, 4'b0000, 4'b0000, 8'h00, 4'b0000, 1'b0));
        for (int k = 0; k <= 8; k++)
            tableQ.push_back(mk(1'b0, 4'b0001, 4'b0000, 8'h01,
                                (k == 4 || k == 8) ? 4'b0001 : 4'b0000, 1'b0));
        for (int k = 0; k < 3; k++)
            tableQ.push_back(mk(1'b0, 4'b0001, 4'b0001, 8'h01, 4'b0000, 1'b0));
        tableQ.push_back(mk(1'b0, 4'b0001, 4'b0000, 8'h01, 4'b0001, 1'b0));
        for (int k = 0; k < 3; k++)
            tableQ.push_back(mk(1'b0, 4'b0001, 4'b0001, 8'h01, 4'b0000, 1'b0));
        tableQ.push_back(mk(1'b0, 4'b0001, 4'b0001, 8'h02, 4'b0000, 1'b0));
        for (int k = 1; k <= 16; k++)
            tableQ.push_back(mk(1'b0, 4'b0001, 4'b0001, 8'h02,
                                (k == 8 || k == 16) ? 4'b0001 : 4'b0000, 1'b0));

        for (int i = 0; i < tableQ.size(); i++) begin
            step(tableQ[i]);
        end

        // Channel 1 longing: 7 absent cycles survive, 8 break the heart.
        step(mk(1'b1, 4'b0000, 4'b0000, 8'h00, 4'b0000, 1'b0));
        step(mk(1'b0, 4'b0010, 4'b0000, 8'h04, 4'b0000, 1'b0));
        for (int k = 1; k <= 7; k++)
            step(mk(1'b0, 4'b0000, 4'b0000, 8'h04, (k == 4) ? 4'b0010 : 4'b0000, 1'b0));
        step(mk(1'b0, 4'b0010, 4'b0000, 8'h04, 4'b0010, 1'b0));
        for (int k = 9; k <= 15; k++)
            step(mk(1'b0, 4'b0000, 4'b0000, 8'h04, (k == 12) ? 4'b0010 : 4'b0000, 1'b0));
        step(mk(1'b0, 4'b0000, 4'b0000, 8'h0C, 4'b0000, 1'b0));
        step(mk(1'b0, 4'b0010, 4'b0000, 8'h0C, 4'b0000, 1'b0));

        // Broken heart offered love and tranquillity together.
`ifdef HEART_MENDING_EN
        step(mk(1'b0, 4'b0010, 4'b0010, 8'h00, 4'b0000, 1'b0));
        step(mk(1'b0, 4'b0000, 4'b0000, 8'h00, 4'b0000, 1'b0));
`else
        for (int k = 0; k < 20; k++)
            step(mk(1'b0, 4'b0010, 4'b0010, 8'h0C, 4'b0000, 1'b0));
`endif

        // Whole chorus reaches peace, then a one-cycle reset clears it.
        step(mk(1'b1, 4'b0000, 4'b0000, 8'h00, 4'b0000, 1'b0));
        step(mk(1'b0, 4'b1111, 4'b1111, 8'h55, 4'b0000, 1'b0));
        for (int k = 0; k < 3; k++)
            step(mk(1'b0, 4'b1111, 4'b1111, 8'h55, 4'b0000, 1'b0));
        step(mk(1'b0, 4'b1111, 4'b1111, 8'hAA, 4'b0000, 1'b0));
        step(mk(1'b0, 4'b1111, 4'b1111, 8'hAA, 4'b0000, 1'b1));
        step(mk(1'b0, 4'b1111, 4'b1111, 8'hAA, 4'b0000, 1'b1));
        step(mk(1'b1, 4'b1111, 4'b1111, 8'h00, 4'b0000, 1'b0));
        step(mk(1'b0, 4'b0000, 4'b0000, 8'h00, 4'b0000, 1'b0));

        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard drain: %0d entries left, expected 0", expQ.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
